// File: rtl/exu_pipe_reg_pkg.sv
// ID->EXU payload layout and pipe-stage occupancy encodings.
// Field order, MSB first: {inst_type, alu_op, lsu_op, wsel, wena, waddr, pc, imm, rdata1, rdata2, csr}.
package exu_pipe_reg_pkg;

  localparam int INST_TYPE_W = 8;
  localparam int ALU_OP_W    = 8;
  localparam int LSU_OP_W    = 4;
  localparam int WSEL_W      = 3;
  localparam int WENA_W      = 1;
  localparam int WADDR_W     = 8;
  localparam int XLEN        = 32;

  localparam int EXU_PAYLOAD_W = INST_TYPE_W + ALU_OP_W + LSU_OP_W + WSEL_W + WENA_W
                               + WADDR_W + 5 * XLEN;

  localparam int CSR_LSB       = 0;
  localparam int RDATA2_LSB    = CSR_LSB + XLEN;
  localparam int RDATA1_LSB    = RDATA2_LSB + XLEN;
  localparam int IMM_LSB       = RDATA1_LSB + XLEN;
  localparam int PC_LSB        = IMM_LSB + XLEN;
  localparam int WADDR_LSB     = PC_LSB + XLEN;
  localparam int WENA_LSB      = WADDR_LSB + WADDR_W;
  localparam int WSEL_LSB      = WENA_LSB + WENA_W;
  localparam int LSU_OP_LSB    = WSEL_LSB + WSEL_W;
  localparam int ALU_OP_LSB    = LSU_OP_LSB + LSU_OP_W;
  localparam int INST_TYPE_LSB = ALU_OP_LSB + ALU_OP_W;

  typedef struct packed {
    logic [INST_TYPE_W-1:0] inst_type;
    logic [ALU_OP_W-1:0]    alu_op;
    logic [LSU_OP_W-1:0]    lsu_op;
    logic [WSEL_W-1:0]      wsel;
    logic [WENA_W-1:0]      wena;
    logic [WADDR_W-1:0]     waddr;
    logic [XLEN-1:0]        pc;
    logic [XLEN-1:0]        imm;
    logic [XLEN-1:0]        rdata1;
    logic [XLEN-1:0]        rdata2;
    logic [XLEN-1:0]        csr;
  } exu_payload_t;

  typedef enum logic [1:0] {
    PIPE_EMPTY = 2'd0,
    PIPE_ONE   = 2'd1,
    PIPE_FULL  = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/exu_pipe_reg.sv
// ID->EXU stage register with flush and stall counter; 1-cycle latency.
// SKID=0: ready is !valid || out_ready; SKID=1: 2-entry skid, ready registered (low only when full).
module exu_pipe_reg
  import exu_pipe_reg_pkg::*;
#(
  parameter int DATA_W = EXU_PAYLOAD_W,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        count_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  pipe_state_e       state;
  logic [DATA_W-1:0] main_dat;
  logic [CNT_W-1:0]  stall_cnt;
  logic              in_fire;
  logic              out_fire;

  assign out_valid_o = (state != PIPE_EMPTY);
  assign out_data_o  = main_dat;
  assign count_o     = state;
  assign stall_cnt_o = stall_cnt;
  assign in_fire     = in_valid_i && in_ready_o;
  assign out_fire    = out_valid_o && out_ready_i;

  generate
    if (SKID == 0) begin : g_single
      assign in_ready_o = !rst && (!out_valid_o || out_ready_i);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state    <= PIPE_EMPTY;
          main_dat <= '0;
        end else if (flush_i) begin
          state <= PIPE_EMPTY;
        end else if (in_fire) begin
          state    <= PIPE_ONE;
          main_dat <= in_data_i;
        end else if (out_fire) begin
          state <= PIPE_EMPTY;
        end
      end
    end else begin : g_skid
      logic [DATA_W-1:0] skid_dat;
      logic              rdy_q;

      // Ready comes straight from a flop so out_ready_i never reaches upstream combinationally.
      assign in_ready_o = rdy_q && !rst;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state    <= PIPE_EMPTY;
          main_dat <= '0;
          skid_dat <= '0;
          rdy_q    <= 1'b1;
        end else if (flush_i) begin
          state <= PIPE_EMPTY;
          rdy_q <= 1'b1;
        end else begin
          case (state)
            PIPE_EMPTY: begin
              if (in_fire) begin
                state    <= PIPE_ONE;
                main_dat <= in_data_i;
              end
            end
            PIPE_ONE: begin
              if (in_fire && out_fire) begin
                main_dat <= in_data_i;
              end else if (in_fire) begin
                state    <= PIPE_FULL;
                skid_dat <= in_data_i;
                rdy_q    <= 1'b0;
              end else if (out_fire) begin
                state <= PIPE_EMPTY;
              end
            end
            PIPE_FULL: begin
              if (out_fire) begin
                state    <= PIPE_ONE;
                main_dat <= skid_dat;
                rdy_q    <= 1'b1;
              end
            end
            default: begin
              state <= PIPE_EMPTY;
              rdy_q <= 1'b1;
            end
          endcase
        end
      end
    end
  endgenerate

  // Counts held-but-refused cycles, including a flush cycle; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid_o && !out_ready_i && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_exu_pipe_reg.sv
// Two stage instances: A (SKID=1, 16-bit counter) and B (SKID=0, 4-bit counter), scoreboarded outputs.
module tb_exu_pipe_reg;

  localparam int DW = 192;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [DW-1:0] a_in_data, a_out_data;
  logic [1:0]    a_count;
  logic [15:0]   a_stall;

  logic          b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [DW-1:0] b_in_data, b_out_data;
  logic [1:0]    b_count;
  logic [3:0]    b_stall;

  exu_pipe_reg #(.DATA_W(DW), .SKID(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .flush_i(a_flush),
    .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .in_data_i(a_in_data),
    .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .out_data_o(a_out_data),
    .count_o(a_count), .stall_cnt_o(a_stall)
  );

  exu_pipe_reg #(.DATA_W(DW), .SKID(0), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .flush_i(b_flush),
    .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .in_data_i(b_in_data),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_data_o(b_out_data),
    .count_o(b_count), .stall_cnt_o(b_stall)
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitors: every output transfer must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && a_out_valid && a_out_ready) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected: got %0h expected nothing at %0t", a_out_data, $time);
      end else begin
        chk("a_order", a_out_data, qa.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected: got %0h expected nothing at %0t", b_out_data, $time);
      end else begin
        chk("b_order", b_out_data, qb.pop_front());
      end
    end
  end

  initial begin
    logic mvalid;
    logic exp_rdy;
    logic acc;

    rst = 1'b1;
    a_flush = 0; a_in_valid = 0; a_out_ready = 0; a_in_data = '0;
    b_flush = 0; b_in_valid = 0; b_out_ready = 0; b_in_data = '0;

    // Reset
    repeat (3) begin
      @(negedge clk);
      chk("a_rdy_in_rst", a_in_ready, 0);
      chk("b_rdy_in_rst", b_in_ready, 0);
    end
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("a_rdy_post_rst", a_in_ready, 1);
    chk("a_valid_rst", a_out_valid, 0);
    chk("a_data_rst", a_out_data, 0);
    chk("a_count_rst", a_count, 0);
    chk("a_stall_rst", a_stall, 0);
    chk("b_rdy_post_rst", b_in_ready, 1);
    chk("b_valid_rst", b_out_valid, 0);
    chk("b_data_rst", b_out_data, 0);
    chk("b_count_rst", b_count, 0);
    chk("b_stall_rst", b_stall, 0);

    // A: streaming 1..8 with out_ready high
    cyc();
    a_out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      a_in_valid = 1; a_in_data = DW'(i); qa.push_back(DW'(i));
      cyc();
      chk("a_stream_data", a_out_data, DW'(i));
      chk("a_stream_valid", a_out_valid, 1);
      chk("a_stream_count", a_count, 1);
    end
    a_in_valid = 0;
    cyc();
    chk("a_stream_drain", a_count, 0);

    // A: fill to FULL under back-pressure, then drain in order
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = DW'('hA);
    qa.push_back(DW'('hA)); qa.push_back(DW'('hB));
    cyc();
    chk("a_one_count", a_count, 1);
    chk("a_one_stall", a_stall, 0);
    a_in_data = DW'('hB);
    cyc();
    a_in_valid = 0;
    chk("a_full_count", a_count, 2);
    chk("a_full_rdy", a_in_ready, 0);
    chk("a_full_data", a_out_data, DW'('hA));
    chk("a_full_stall", a_stall, 1);
    for (int k = 2; k <= 4; k++) begin
      cyc();
      chk("a_stall_inc", a_stall, DW'(k));
      chk("a_hold_data", a_out_data, DW'('hA));
      chk("a_hold_valid", a_out_valid, 1);
    end
    a_out_ready = 1;
    cyc();
    chk("a_skid_to_main", a_out_data, DW'('hB));
    chk("a_skid_count", a_count, 1);
    chk("a_skid_rdy", a_in_ready, 1);
    chk("a_skid_stall", a_stall, 4);
    cyc();
    chk("a_skid_drain", a_count, 0);

    // A: flush while FULL with 0xC offered
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = DW'('hD);
    cyc();
    a_in_data = DW'('hE);
    cyc();
    chk("a_pre_flush_count", a_count, 2);
    a_in_data = DW'('hC); a_flush = 1;
    cyc();
    a_flush = 0; a_in_valid = 0;
    chk("a_flush_valid", a_out_valid, 0);
    chk("a_flush_count", a_count, 0);
    chk("a_flush_rdy", a_in_ready, 1);
    chk("a_flush_data_kept", a_out_data, DW'('hD));
    chk("a_flush_stall", a_stall, 6);
    a_out_ready = 1;
    repeat (3) cyc();
    chk("a_post_flush_count", a_count, 0);
    a_in_valid = 1; a_in_data = DW'(7); qa.push_back(DW'(7));
    cyc();
    a_in_valid = 0;
    chk("a_post_flush_accept", a_out_data, DW'(7));
    cyc();
    chk("a_post_flush_drain", a_count, 0);

    // B: streaming 1..8
    b_out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      b_in_valid = 1; b_in_data = DW'(i + 'h10); qb.push_back(DW'(i + 'h10));
      #1;
      chk("b_stream_rdy", b_in_ready, 1);
      cyc();
      chk("b_stream_data", b_out_data, DW'(i + 'h10));
      chk("b_stream_count", b_count, 1);
    end
    b_in_valid = 0;
    cyc();
    chk("b_stream_drain", b_count, 0);

    // B: stall counter saturation with 4-bit counter
    b_out_ready = 0;
    b_in_valid = 1; b_in_data = DW'('h55); qb.push_back(DW'('h55));
    cyc();
    b_in_valid = 0;
    chk("b_sat_start", b_stall, 0);
    chk("b_sat_rdy", b_in_ready, 0);
    for (int k = 1; k <= 20; k++) begin
      cyc();
      chk("b_sat_stall", b_stall, DW'((k < 15) ? k : 15));
      chk("b_sat_data", b_out_data, DW'('h55));
    end
    b_out_ready = 1;
    #1;
    chk("b_comb_rdy", b_in_ready, 1);
    cyc();
    chk("b_sat_drain", b_out_valid, 0);
    chk("b_sat_hold", b_stall, 15);

    // B: toggling out_ready with random input stream against a reference model
    mvalid = 0;
    for (int n = 0; n < 40; n++) begin
      b_out_ready = (n % 2 == 0);
      b_in_valid = 1'($urandom_range(0, 1));
      for (int w = 0; w < DW / 32; w++) b_in_data[w*32 +: 32] = $urandom();
      @(negedge clk);
      exp_rdy = !mvalid || b_out_ready;
      chk("b_rand_rdy", b_in_ready, exp_rdy);
      chk("b_rand_valid", b_out_valid, mvalid);
      acc = b_in_valid && exp_rdy;
      if (acc) qb.push_back(b_in_data);
      if (acc) mvalid = 1;
      else if (mvalid && b_out_ready) mvalid = 0;
      cyc();
    end
    b_in_valid = 0; b_out_ready = 1;
    repeat (3) cyc();

    chk("a_queue_empty", DW'(qa.size()), 0);
    chk("b_queue_empty", DW'(qb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
